// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants for the seven-segment scan controller.
//   SEG_TABLE : active-low segment patterns (gfedcba, bit 0 = a) for hex 0..F
//   SEG_OFF   : all segments off
//   idx_w()   : width of a digit index for a given digit count (never below 1)
package ssd_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int idx_w(input int digits);
        int w;
        w = $clog2(digits);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_to_ssd.sv
// hex_to_ssd -- combinational hex nibble to active-low segment decoder.
//   nib : input  [3:0] hex value
//   seg : output [6:0] active-low segments, gfedcba (seg[0] = a)
module hex_to_ssd
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- multiplexed seven-segment display scanner with
// tear-free (frame-synchronous) display updates.
//   Parameters: DIGITS (1..8) multiplexed digits, DIV_W prescaler width;
//               each digit slot lasts 2^DIV_W clk cycles.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data       : 4*DIGITS hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   load       : capture strobe for data
//   blank      : per-digit force-off mask, sampled live
//   an         : active-low anode enables (registered)
//   cat        : active-low segments gfedcba (registered)
//   upd_pend   : a captured value is waiting for the next frame boundary
//   frame_done : high during the cycle of each frame boundary
// Optional build macro SSD_LZB_EN enables leading-zero blanking
// (digit 0 is never auto-blanked).
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            cat,
    output logic                  upd_pend,
    output logic                  frame_done
);

    localparam int                IDX_W    = idx_w(DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                upd_pend_q, upd_pend_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          cat_q, cat_d;

    logic                slot_tick;
    logic                frame_bnd;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;

    assign slot_tick = &presc_q;
    assign frame_bnd = slot_tick && (idx_q == IDX_LAST);

    // Nibble of the display register addressed by the current index.
    always_comb begin
        cur_nib = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib = disp_q[4*k +: 4];
            end
        end
    end

    hex_to_ssd u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

`ifdef SSD_LZB_EN
    // lz_off[k] is set when nibbles k..DIGITS-1 are all zero; built from the
    // most significant digit downwards as a running "all zero so far" flag.
    logic [DIGITS-1:0] lz_off;

    always_comb begin
        logic run;
        run       = 1'b1;
        lz_off    = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run       = run & (disp_q[4*k +: 4] == 4'h0);
            lz_off[k] = run;
        end
    end
`endif

    always_comb begin
        presc_d    = presc_q + DIV_W'(1);
        idx_d      = idx_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        upd_pend_d = upd_pend_q;
        an_d       = '1;
        cat_d      = cur_seg;

        if (slot_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (load) begin
            pend_d     = data;
            upd_pend_d = 1'b1;
        end

        // Display only ever changes on a frame boundary; a load landing on
        // the boundary itself bypasses the pending register.
        if (frame_bnd) begin
            disp_d     = load ? data : pend_q;
            upd_pend_d = 1'b0;
        end

        for (int k = 0; k < DIGITS; k++) begin
`ifdef SSD_LZB_EN
            an_d[k] = !((idx_q == IDX_W'(k)) && !blank[k] && !lz_off[k]);
`else
            an_d[k] = !((idx_q == IDX_W'(k)) && !blank[k]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            disp_q     <= '0;
            upd_pend_q <= 1'b0;
            an_q       <= '1;
            cat_q      <= SEG_OFF;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            upd_pend_q <= upd_pend_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
        end
    end

    assign an         = an_q;
    assign cat        = cat_q;
    assign upd_pend   = upd_pend_q;
    assign frame_done = frame_bnd;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl -- self-checking bench for ssd_scan_ctrl.
// Main instance: DIGITS=4, DIV_W=2. Second instance: DIGITS=1, DIV_W=3.
// A cycle-level reference model derives slot/index from elapsed cycles.
module tb_ssd_scan_ctrl;

    localparam int P  = 4;   // cycles per slot (2^DIV_W)
    localparam int D  = 4;   // digits
    localparam int P1 = 8;   // cycles per slot, single-digit instance

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic        load = 1'b0;
    logic [3:0]  blank = '0;
    logic [3:0]  an;
    logic [6:0]  cat;
    logic        upd_pend;
    logic        frame_done;

    logic [0:0]  an1;
    logic [6:0]  cat1;
    logic        upd_pend1;
    logic        frame_done1;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(4), .DIV_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .load       (load),
        .blank      (blank),
        .an         (an),
        .cat        (cat),
        .upd_pend   (upd_pend),
        .frame_done (frame_done)
    );

    ssd_scan_ctrl #(.DIGITS(1), .DIV_W(3)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data[3:0]),
        .load       (load),
        .blank      (1'b0),
        .an         (an1),
        .cat        (cat1),
        .upd_pend   (upd_pend1),
        .frame_done (frame_done1)
    );

    // Reference segment patterns (active low, gfedcba).
    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: m_t = rising edges since reset release.
    int          m_t;
    logic [15:0] m_pend, m_disp;
    logic        m_upd;
    logic [3:0]  m_an;
    logic [6:0]  m_cat;
    logic        m_an1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, m_t, $time);
        end
    endtask

    function automatic int cur_idx();
        return (m_t / P) % D;
    endfunction

    function automatic bit is_bnd();
        return (rst_n === 1'b1) && ((m_t % (P * D)) == P * D - 1);
    endfunction

    function automatic bit is_bnd1();
        return (rst_n === 1'b1) && ((m_t % P1) == P1 - 1);
    endfunction

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_pend = '0;
        m_disp = '0;
        m_upd  = 1'b0;
        m_an   = 4'hF;
        m_cat  = 7'h7F;
        m_an1  = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        int         idx;
        bit         off;
        logic [3:0] one_hot;
        logic [15:0] upper;
        if (rst_n !== 1'b1) return;
        idx = cur_idx();
        off = blank[idx];
`ifdef SSD_LZB_EN
        upper = m_disp >> (4 * idx);
        if (idx > 0 && upper == 16'h0) off = 1'b1;
`else
        upper = '0;
`endif
        one_hot = 4'(1 << idx);
        m_an  = off ? 4'hF : ~one_hot;
        m_cat = seg_ref[nib_of(m_disp, idx)];
        m_an1 = 1'b0;
        if (is_bnd()) begin
            m_disp = load ? data : m_pend;
            m_upd  = 1'b0;
        end else if (load) begin
            m_upd = 1'b1;
        end
        if (load) m_pend = data;
        m_t++;
    endtask

    task automatic check_all();
        check("an", 32'(an), 32'(m_an));
        check("cat", 32'(cat), 32'(m_cat));
        check("upd_pend", 32'(upd_pend), 32'(m_upd));
        check("frame_done", 32'(frame_done), 32'(is_bnd()));
        check("an_1digit", 32'(an1), 32'(m_an1));
        check("frame_done_1digit", 32'(frame_done1), 32'(is_bnd1()));
    endtask

    // Called at a falling edge: drive inputs, advance model, check next falling edge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] bl);
        load  = ld;
        data  = d;
        blank = bl;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        blank = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic [3:0] bl);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, bl);
    endtask

    task automatic run_until_phase(input int ph, input string tag);
        int guard;
        guard = 0;
        while ((m_t % (P * D)) != ph && guard < 64) begin
            step(1'b0, 16'h0, 4'h0);
            guard++;
        end
        if (guard >= 64) check(tag, 32'(guard), 32'(0));
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1, 0) == 1) v = v | (16'($urandom_range(15, 0)) << (4 * k));
        end
        return v;
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Scan pattern after loading 1234 and letting it commit.
        step(1'b1, 16'h1234, 4'h0);
        idle(40, 4'h0);

        // Mid-frame load stays pending until the frame boundary.
        run_until_phase(5, "wait_midframe");
        step(1'b1, 16'hABCD, 4'h0);
        idle(40, 4'h0);

        // Load coinciding with the frame boundary goes straight to display.
        run_until_phase(P * D - 1, "wait_boundary");
        step(1'b1, 16'h00FF, 4'h0);
        idle(24, 4'h0);

        // Blank digit 2.
        idle(20, 4'b0100);

        // Reset mid-frame with a value pending.
        step(1'b1, 16'h5678, 4'h0);
        run_until_phase(6, "wait_reset_point");
        do_reset();
        idle(24, 4'h0);

        // Leading-zero style values, then random traffic.
        step(1'b1, 16'h0050, 4'h0);
        idle(36, 4'h0);
        step(1'b1, 16'h0000, 4'h0);
        idle(36, 4'h0);

        for (int i = 0; i < 800; i++) begin
            logic       ld;
            logic [3:0] bl;
            ld = ($urandom_range(7, 0) == 0);
            bl = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
            if ($urandom_range(299, 0) == 0) begin
                do_reset();
            end else begin
                step(ld, rand_data(), bl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of multiplexed digits; legal range 1..8.
REQ-002 The block SHALL have parameter DIV_W, default 16, giving the refresh prescaler width; one digit slot lasts 2^DIV_W clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data, input, 4*DIGITS bits: hex nibbles, with nibble k driving digit k (digit 0 = LSB, rightmost).
REQ-006 The block SHALL have port load, input, 1 bit: capture strobe for data.
REQ-007 The block SHALL have port blank, input, DIGITS bits: per-digit force-off mask, sampled live.
REQ-008 The block SHALL have port an, output, DIGITS bits: active-low anode enables, at most one low at a time.
REQ-009 The block SHALL have port cat, output, 7 bits: active-low segments, bit order gfedcba (cat[0] = a).
REQ-010 The block SHALL have port upd_pend, output, 1 bit: high while a captured value awaits commit.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 A DIV_W-bit prescaler SHALL increment every cycle and wrap; a slot tick SHALL occur in the cycle it equals all-ones.
REQ-013 On a slot tick, the digit index SHALL advance by 1, and from DIGITS-1 it SHALL wrap to 0.
REQ-014 A frame boundary SHALL be a slot tick with index = DIGITS-1.
REQ-015 On load=1, data SHALL be captured into the pending register, and upd_pend SHALL be set.
REQ-016 At a frame boundary, the display register SHALL take the pending value, upd_pend SHALL clear, and frame_done SHALL be 1 for exactly that cycle.
REQ-017 If load=1 coincides with a frame boundary, the display SHALL take the current data directly and upd_pend SHALL remain 0.
REQ-018 The display register SHALL never change mid-frame, so that there is no tearing.
REQ-019 an and cat SHALL be registered, reflecting the index and display one cycle after each index change.
REQ-020 an SHALL be ~(1<<idx), except all ones when blank[idx]=1.
REQ-021 cat SHALL be the decoded hex nibble: 0..F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-022 If DIGITS=1, the index SHALL be held at 0 and every slot tick SHALL be a frame boundary.

Reset
REQ-023 While rst_n=0, prescaler, index, pending, display, upd_pend and frame_done SHALL be 0, an SHALL be all ones and cat SHALL be 7'h7F.
REQ-024 Reset asserted mid-frame SHALL discard any pending value.
REQ-025 Scan SHALL resume at digit 0 with a fresh prescaler after rst_n rises.

Configuration
REQ-026 With macro SSD_LZB_EN defined, leading-zero blanking SHALL apply: digit k>0 SHALL be off (an bit high) when display nibbles k..DIGITS-1 are all zero, and digit 0 SHALL never be auto-blanked.
REQ-027 Without SSD_LZB_EN, no automatic blanking SHALL occur and there SHALL be no extra logic.

Structure
REQ-028 Package ssd_pkg SHALL hold the 16-entry segment table constant, the blank-pattern constant SEG_OFF = 7'h7F, and the index-width helper max(1,$clog2(DIGITS)).
REQ-029 Sub-module hex_to_ssd SHALL provide combinational nibble-to-cat decoding using ssd_pkg.
REQ-030 All other logic (prescaler, index, pending/display registers, output registers) SHALL reside in ssd_scan_ctrl.

Verification (DIGITS=4, DIV_W=2 unless stated)
REQ-031 Scan: load data=16'h1234 after reset, then wait for commit -> an cycles 1110,1101,1011,0111 with cat 19,30,24,79, each held 4 cycles.
REQ-032 Anti-tear: load 16'hABCD mid-frame -> upd_pend=1, displayed digits unchanged until frame_done, then upd_pend=0 and new cat values from next slot.
REQ-033 Coincident load: assert load exactly on the frame boundary with 16'h00FF -> next frame shows F,F,0,0 immediately and upd_pend stays 0.
REQ-034 Blank and reset: blank=4'b0100 -> an=1111 during the digit-2 slot; rst_n pulsed low mid-frame -> an=1111, cat=7F, then restart at digit 0 with display 0.
REQ-035 With SSD_LZB_EN, display 16'h0050 -> digits 3 and 2 off, digit 1 cat=12, digit 0 cat=40; display 16'h0000 -> only digit 0 lit with cat=40.
REQ-036 With DIGITS=1, DIV_W=3 -> an=0 constantly and frame_done pulses every 8 cycles.
